if_id_reg: RTL and testbench

//  IF/ID pipeline register of the RV32I 5-stage CPU.
//  - Captures fetch-stage outputs on each rising clk edge and holds them for the decode stage:
//    PC, PC+4, the decoded instruction fields and the generated immediate.
//  - Supports stall (hold) and flush (insert NOP bubble) for hazard and branch handling.

---
 rtl/if_id_if.sv | 46 ++++
 rtl/if_id_reg.sv | 84 ++++++++
 tb/tb_if_id_reg.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_if.sv
// IF/ID boundary bundle: fetch-side fields in (*_if) and their decode-side copies out (*_id).
// Latency is set by the attached register, not by this bundle.
// Backpressure is the stall/flush pair carried alongside the data.
interface if_id_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            flush;

    logic [XLEN-1:0] pc_if;
    logic [XLEN-1:0] pc_plus_4_if;
    logic [6:0]      opcode_if;
    logic [4:0]      rd_if;
    logic [2:0]      func_3_if;
    logic [4:0]      rs1_if;
    logic [4:0]      rs2_if;
    logic            func_7_bit_6_if;
    logic [XLEN-1:0] im_data_if;

    logic [XLEN-1:0] pc_id;
    logic [XLEN-1:0] pc_plus_4_id;
    logic [6:0]      opcode_id;
    logic [4:0]      rd_id;
    logic [2:0]      func_3_id;
    logic [4:0]      rs1_id;
    logic [4:0]      rs2_id;
    logic            func_7_bit_6_id;
    logic [XLEN-1:0] im_data_id;
    logic            valid_id;

    modport master (
        output stall, flush,
        output pc_if, pc_plus_4_if, opcode_if, rd_if, func_3_if,
        output rs1_if, rs2_if, func_7_bit_6_if, im_data_if,
        input  pc_id, pc_plus_4_id, opcode_id, rd_id, func_3_id,
        input  rs1_id, rs2_id, func_7_bit_6_id, im_data_id, valid_id
    );

    modport slave (
        input  stall, flush,
        input  pc_if, pc_plus_4_if, opcode_if, rd_if, func_3_if,
        input  rs1_if, rs2_if, func_7_bit_6_if, im_data_if,
        output pc_id, pc_plus_4_id, opcode_id, rd_id, func_3_id,
        output rs1_id, rs2_id, func_7_bit_6_id, im_data_id, valid_id
    );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds fetch outputs for decode, with stall and NOP-bubble flush.
// Latency: one rising clk edge, no combinational in->out path.
// Backpressure: stall holds everything; flush wins over stall and loads addi x0,x0,0 with valid_id=0.
module if_id_reg #(
    parameter int         XLEN    = 32,
    parameter logic [6:0] NOP_OPC = 7'b0010011
) (
    input  logic    clk,
    input  logic    rst_n,
    if_id_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus_4;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      func_3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            func_7_bit_6;
        logic [XLEN-1:0] im_data;
    } stage_t;

    localparam stage_t NOP_STAGE = '{
        pc:           '0,
        pc_plus_4:    '0,
        opcode:       NOP_OPC,
        rd:           '0,
        func_3:       '0,
        rs1:          '0,
        rs2:          '0,
        func_7_bit_6: 1'b0,
        im_data:      '0
    };

    stage_t stage_in;
    stage_t stage_d, stage_q;
    logic   valid_d, valid_q;

    assign stage_in = '{
        pc:           bus.pc_if,
        pc_plus_4:    bus.pc_plus_4_if,
        opcode:       bus.opcode_if,
        rd:           bus.rd_if,
        func_3:       bus.func_3_if,
        rs1:          bus.rs1_if,
        rs2:          bus.rs2_if,
        func_7_bit_6: bus.func_7_bit_6_if,
        im_data:      bus.im_data_if
    };

    always_comb begin
        stage_d = stage_q;
        valid_d = valid_q;
        if (bus.flush) begin
            stage_d = NOP_STAGE;
            valid_d = 1'b0;
        end else if (!bus.stall) begin
            stage_d = stage_in;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= NOP_STAGE;
            valid_q <= 1'b0;
        end else begin
            stage_q <= stage_d;
            valid_q <= valid_d;
        end
    end

    assign bus.pc_id           = stage_q.pc;
    assign bus.pc_plus_4_id    = stage_q.pc_plus_4;
    assign bus.opcode_id       = stage_q.opcode;
    assign bus.rd_id           = stage_q.rd;
    assign bus.func_3_id       = stage_q.func_3;
    assign bus.rs1_id          = stage_q.rs1;
    assign bus.rs2_id          = stage_q.rs2;
    assign bus.func_7_bit_6_id = stage_q.func_7_bit_6;
    assign bus.im_data_id      = stage_q.im_data;
    assign bus.valid_id        = valid_q;
endmodule

// File: tb/tb_if_id_reg.sv
// Directed bench for if_id_reg: reset, load, timed input stream, stall, flush, async reset.
module tb_if_id_reg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [6:0]  opc;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        f7;
        logic [31:0] im;
    } vec_t;

    localparam vec_t NOP = '{pc: 32'h0, pc4: 32'h0, opc: 7'h13, rd: 5'd0, f3: 3'd0,
                             rs1: 5'd0, rs2: 5'd0, f7: 1'b0, im: 32'h0};
    localparam vec_t T2  = '{pc: 32'h0000_0040, pc4: 32'h0000_0044, opc: 7'h33, rd: 5'd5,
                             f3: 3'd0, rs1: 5'd1, rs2: 5'd2, f7: 1'b1, im: 32'h0};
    localparam vec_t VA  = '{pc: 32'h0000_1000, pc4: 32'h0000_1004, opc: 7'h03, rd: 5'd10,
                             f3: 3'd2, rs1: 5'd2, rs2: 5'd8, f7: 1'b0, im: 32'hFFFF_FFF8};
    localparam vec_t VB  = '{pc: 32'hFFFF_FFFC, pc4: 32'h0000_0000, opc: 7'h6F, rd: 5'd31,
                             f3: 3'd7, rs1: 5'd31, rs2: 5'd31, f7: 1'b0, im: 32'h8000_0000};

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    vec_t cur;
    vec_t got;
    vec_t exp_s;

    always #10 clk = ~clk;

    if_id_if #(.XLEN(32)) bus ();

    if_id_reg #(.XLEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign got = '{pc: bus.pc_id, pc4: bus.pc_plus_4_id, opc: bus.opcode_id, rd: bus.rd_id,
                   f3: bus.func_3_id, rs1: bus.rs1_id, rs2: bus.rs2_id,
                   f7: bus.func_7_bit_6_id, im: bus.im_data_id};

    task automatic drive(input vec_t v);
        cur                 = v;
        bus.pc_if           = v.pc;
        bus.pc_plus_4_if    = v.pc4;
        bus.opcode_if       = v.opc;
        bus.rd_if           = v.rd;
        bus.func_3_if       = v.f3;
        bus.rs1_if          = v.rs1;
        bus.rs2_if          = v.rs2;
        bus.func_7_bit_6_if = v.f7;
        bus.im_data_if      = v.im;
    endtask

    task automatic check(input string tag, input vec_t exp, input logic exp_v);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s fields observed=%h expected=%h", tag, got, exp);
        end
        total++;
        assert (bus.valid_id === exp_v) else begin
            bad++;
            $error("FAIL %s valid_id observed=%b expected=%b", tag, bus.valid_id, exp_v);
        end
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        v.pc  = $urandom;
        v.pc4 = $urandom;
        v.opc = 7'($urandom);
        v.rd  = 5'($urandom);
        v.f3  = 3'($urandom);
        v.rs1 = 5'($urandom);
        v.rs2 = 5'($urandom);
        v.f7  = 1'($urandom);
        v.im  = $urandom;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive(VA);

        // The edge at 10ns loads VA; reset at 15ns must clear it without any edge.
        #15;
        rst_n = 1'b0;
        #1 check("reset_async", NOP, 1'b0);
        drive(VB);
        @(posedge clk); #1 check("reset_held", NOP, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(T2);
        @(posedge clk); #1 check("load", T2, 1'b1);

        @(negedge clk);
        drive(VB);
        #1 check("between_edges", T2, 1'b1);
        @(posedge clk); #1 check("load_b", VB, 1'b1);

        // Inputs change every 25ns starting 2ns after an edge, so never on an edge.
        @(posedge clk);
        #2;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    drive(rand_vec());
                    #25;
                end
            end
            begin
                for (int k = 0; k < 6; k++) begin
                    @(posedge clk);
                    exp_s = cur;
                    #1 check("stream", exp_s, 1'b1);
                end
            end
        join

        @(negedge clk);
        drive(VA);
        @(posedge clk); #1 check("stall_pre", VA, 1'b1);
        @(negedge clk);
        bus.stall = 1'b1;
        drive(VB);
        @(posedge clk); #1 check("stall_1", VA, 1'b1);
        @(posedge clk); #1 check("stall_2", VA, 1'b1);
        @(negedge clk);
        bus.stall = 1'b0;
        @(posedge clk); #1 check("stall_release", VB, 1'b1);

        @(negedge clk);
        drive(VA);
        @(posedge clk); #1 check("flush_pre", VA, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        drive(VB);
        @(posedge clk); #1 check("flush_over_stall", NOP, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        @(posedge clk); #1 check("stall_bubble", NOP, 1'b0);
        @(negedge clk);
        bus.stall = 1'b0;
        drive(VA);
        @(posedge clk); #1 check("after_bubble", VA, 1'b1);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk); #1 check("flush_only", NOP, 1'b0);
        @(negedge clk);
        bus.flush = 1'b0;
        drive(VB);
        @(posedge clk); #1 check("flush_release", VB, 1'b1);

        @(negedge clk);
        drive(VA);
        @(posedge clk); #1 check("mid_pre", VA, 1'b1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1 check("mid_reset", NOP, 1'b0);
        drive(VB);
        #3;
        rst_n = 1'b1;
        #1 check("mid_release_no_edge", NOP, 1'b0);
        @(posedge clk); #1 check("mid_first_edge", VB, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
